uart_bus_arb: RTL and testbench

UART_BUS_ARB -- requirements
Module: uart_bus_arb

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_bus_arb_rr_arb2.sv | 26 ++
 rtl/uart_bus_arb.sv | 136 +++++++++++++
 tb/tb_uart_bus_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-requester iob_uart native-bus arbiter:
// FSM encoding, default parameters and the forced-completion read data.
package uart_arb_pkg;

  localparam int unsigned ADDR_W_DEF      = 3;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 256;
  localparam int unsigned STRB_W          = 4;

  // Wide enough for any DATA_W in use; truncated at the point of use.
  localparam logic [255:0] TIMEOUT_RDATA = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

endpackage

// File: rtl/uart_bus_arb_rr_arb2.sv
// Two-way round-robin grant; the pointer flips to the other requester
// only when the FSM reports a completed transaction.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] grant_c
);

  logic prio_m1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_m1_q <= 1'b0;
    end else if (done[0]) begin
      prio_m1_q <= 1'b1;
    end else if (done[1]) begin
      prio_m1_q <= 1'b0;
    end
  end

  assign grant_c[0] = req[0] & (~req[1] | ~prio_m1_q);
  assign grant_c[1] = req[1] & (~req[0] |  prio_m1_q);

endmodule

// File: rtl/uart_bus_arb.sv
// Arbitrates two requesters onto one iob_uart native bus.
// Optional slave-response timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_bus_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  output logic [1:0]        gnt,
  output logic              timeout
);

  localparam logic [DATA_W-1:0] TO_RDATA = DATA_W'(TIMEOUT_RDATA);

  state_t     state_q, state_d;
  logic [1:0] grant_c;
  logic [1:0] done_c;
  logic       to_hit_c;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1_valid, m0_valid}),
    .done    (done_c),
    .grant_c (grant_c)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Sits at zero in IDLE so every grant starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (!s_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign to_hit_c = ((state_q == BUSY0 && m0_valid) || (state_q == BUSY1 && m1_valid)) &&
                    !s_ready && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit_c = 1'b0;
`endif

  assign timeout = to_hit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the combinational bus/requester steering.
  always_comb begin
    state_d   = state_q;
    done_c    = 2'b00;
    gnt       = 2'b00;
    s_valid   = 1'b0;
    s_address = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    case (state_q)
      IDLE: begin
        if (grant_c[0]) begin
          state_d = BUSY0;
        end else if (grant_c[1]) begin
          state_d = BUSY1;
        end
      end
      BUSY0: begin
        gnt       = 2'b01;
        s_valid   = m0_valid;
        s_address = m0_address;
        s_wdata   = m0_wdata;
        s_wstrb   = m0_wstrb;
        m0_ready  = m0_valid & (s_ready | to_hit_c);
        m0_rdata  = to_hit_c ? TO_RDATA : s_rdata;
        if (!m0_valid) begin
          state_d = IDLE;
        end else if (s_ready || to_hit_c) begin
          state_d = IDLE;
          done_c  = 2'b01;
        end
      end
      BUSY1: begin
        gnt       = 2'b10;
        s_valid   = m1_valid;
        s_address = m1_address;
        s_wdata   = m1_wdata;
        s_wstrb   = m1_wstrb;
        m1_ready  = m1_valid & (s_ready | to_hit_c);
        m1_rdata  = to_hit_c ? TO_RDATA : s_rdata;
        if (!m1_valid) begin
          state_d = IDLE;
        end else if (s_ready || to_hit_c) begin
          state_d = IDLE;
          done_c  = 2'b10;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_arb.sv
// Directed, table-driven bench for uart_bus_arb (TIMEOUT_CYC=8); the
// timeout sequence follows UART_ARB_TIMEOUT_EN as the RTL does.
module tb_uart_bus_arb;

  logic        clk;
  logic        rst_n;
  logic        m0_valid, m1_valid;
  logic [2:0]  m0_address, m1_address;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [2:0]  s_address;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [1:0]  gnt;
  logic        timeout;

  int n_chk;
  int n_fail;

  uart_bus_arb #(.ADDR_W(3), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_valid   (m0_valid),
    .m0_address (m0_address),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_rdata   (m0_rdata),
    .m0_ready   (m0_ready),
    .m1_valid   (m1_valid),
    .m1_address (m1_address),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_rdata   (m1_rdata),
    .m1_ready   (m1_ready),
    .s_valid    (s_valid),
    .s_address  (s_address),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .s_ready    (s_ready),
    .gnt        (gnt),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        m0v; logic [2:0] m0a; logic [31:0] m0d; logic [3:0] m0s;
    logic        m1v; logic [2:0] m1a; logic [31:0] m1d; logic [3:0] m1s;
    logic        srdy; logic [31:0] srd;
    logic        sv;  logic [2:0] sa;  logic [31:0] sd;  logic [3:0] ss;
    logic        r0;  logic [31:0] d0;
    logic        r1;  logic [31:0] d1;
    logic [1:0]  g;   logic        to;
  } vec_t;

  localparam int NV = 36;
  vec_t vt [NV];

  function automatic vec_t mk(
    input int rs,
    input int m0v, input int m0a, input int m0d, input int m0s,
    input int m1v, input int m1a, input int m1d, input int m1s,
    input int srdy, input int srd,
    input int sv, input int sa, input int sd, input int ss,
    input int r0, input int d0, input int r1, input int d1,
    input int g, input int to);
    vec_t v;
    v.rst_n = 1'(rs);
    v.m0v = 1'(m0v); v.m0a = 3'(m0a); v.m0d = 32'(m0d); v.m0s = 4'(m0s);
    v.m1v = 1'(m1v); v.m1a = 3'(m1a); v.m1d = 32'(m1d); v.m1s = 4'(m1s);
    v.srdy = 1'(srdy); v.srd = 32'(srd);
    v.sv = 1'(sv); v.sa = 3'(sa); v.sd = 32'(sd); v.ss = 4'(ss);
    v.r0 = 1'(r0); v.d0 = 32'(d0); v.r1 = 1'(r1); v.d1 = 32'(d1);
    v.g = 2'(g); v.to = 1'(to);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n      = v.rst_n;
    m0_valid   = v.m0v; m0_address = v.m0a; m0_wdata = v.m0d; m0_wstrb = v.m0s;
    m1_valid   = v.m1v; m1_address = v.m1a; m1_wdata = v.m1d; m1_wstrb = v.m1s;
    s_ready    = v.srdy; s_rdata = v.srd;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("s_valid",   i, 64'(s_valid),   64'(v.sv));
    chk("s_address", i, 64'(s_address), 64'(v.sa));
    chk("s_wdata",   i, 64'(s_wdata),   64'(v.sd));
    chk("s_wstrb",   i, 64'(s_wstrb),   64'(v.ss));
    chk("m0_ready",  i, 64'(m0_ready),  64'(v.r0));
    chk("m0_rdata",  i, 64'(m0_rdata),  64'(v.d0));
    chk("m1_ready",  i, 64'(m1_ready),  64'(v.r1));
    chk("m1_rdata",  i, 64'(m1_rdata),  64'(v.d1));
    chk("gnt",       i, 64'(gnt),       64'(v.g));
    chk("timeout",   i, 64'(timeout),   64'(v.to));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // rst, m0{v,a,d,s}, m1{v,a,d,s}, s_ready, s_rdata | s{v,a,d,s}, r0,d0, r1,d1, gnt, timeout
    // Single M0 read of addr 3, slave returns 0x5A
    vt[0]  = mk(1, 1,3,0,0,       0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[1]  = mk(1, 1,3,0,0,       0,0,0,0,       0,0,     1,3,0,0,       0,0,    0,0,    1,0);
    vt[2]  = mk(1, 1,3,0,0,       0,0,0,0,       1,'h5A,  1,3,0,0,       1,'h5A, 0,0,    1,0);
    vt[3]  = mk(1, 0,0,0,0,       0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[4]  = mk(0, 0,0,0,0,       0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    // Persistent requests from both: M0, M1, M0, M1
    vt[5]  = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[6]  = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    1,'h11,  1,1,'hA0,'hF,  1,'h11, 0,0,    1,0);
    vt[7]  = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[8]  = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    1,'h22,  1,6,'hB1,3,    0,0,    1,'h22, 2,0);
    vt[9]  = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[10] = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    1,'h33,  1,1,'hA0,'hF,  1,'h33, 0,0,    1,0);
    vt[11] = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[12] = mk(1, 1,1,'hA0,'hF,  1,6,'hB1,3,    1,'h44,  1,6,'hB1,3,    0,0,    1,'h44, 2,0);
    // M1 write arrives while M0 is busy
    vt[13] = mk(1, 1,2,0,0,       0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[14] = mk(1, 1,2,0,0,       1,5,'h41,1,    0,0,     1,2,0,0,       0,0,    0,0,    1,0);
    vt[15] = mk(1, 1,2,0,0,       1,5,'h41,1,    1,'h77,  1,2,0,0,       1,'h77, 0,0,    1,0);
    vt[16] = mk(1, 0,0,0,0,       1,5,'h41,1,    0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[17] = mk(1, 0,0,0,0,       1,5,'h41,1,    1,0,     1,5,'h41,1,    0,0,    1,0,    2,0);
    // s_ready in IDLE, then M0 abort keeps M0 priority
    vt[18] = mk(1, 0,0,0,0,       0,0,0,0,       1,'h99,  0,0,0,0,       0,0,    0,0,    0,0);
    vt[19] = mk(1, 1,4,0,0,       0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[20] = mk(1, 1,4,0,0,       0,0,0,0,       0,0,     1,4,0,0,       0,0,    0,0,    1,0);
    vt[21] = mk(1, 0,0,0,0,       0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    1,0);
    vt[22] = mk(1, 1,4,0,0,       1,7,'hC2,'hC,  0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[23] = mk(1, 1,4,0,0,       1,7,'hC2,'hC,  1,'h55,  1,4,0,0,       1,'h55, 0,0,    1,0);
    vt[24] = mk(1, 0,0,0,0,       1,7,'hC2,'hC,  0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[25] = mk(1, 0,0,0,0,       1,7,'hC2,'hC,  1,'h66,  1,7,'hC2,'hC,  0,0,    1,'h66, 2,0);
    // Reset during BUSY1 with slave ready pending
    vt[26] = mk(1, 1,3,'hD3,8,    0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[27] = mk(1, 1,3,'hD3,8,    0,0,0,0,       1,0,     1,3,'hD3,8,    1,0,    0,0,    1,0);
    vt[28] = mk(1, 0,0,0,0,       1,1,'hE4,2,    0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[29] = mk(1, 0,0,0,0,       1,1,'hE4,2,    0,0,     1,1,'hE4,2,    0,0,    0,0,    2,0);
    vt[30] = mk(0, 1,3,'hD3,8,    1,1,'hE4,2,    1,'h88,  0,0,0,0,       0,0,    0,0,    0,0);
    vt[31] = mk(1, 1,3,'hD3,8,    1,1,'hE4,2,    1,'h88,  0,0,0,0,       0,0,    0,0,    0,0);
    vt[32] = mk(1, 1,3,'hD3,8,    1,1,'hE4,2,    1,'h88,  1,3,'hD3,8,    1,'h88, 0,0,    1,0);
    // One M1 transaction so M0 holds priority before the timeout sequence
    vt[33] = mk(1, 0,0,0,0,       1,1,'hE4,2,    0,0,     0,0,0,0,       0,0,    0,0,    0,0);
    vt[34] = mk(1, 0,0,0,0,       1,1,'hE4,2,    1,0,     1,1,'hE4,2,    0,0,    1,0,    2,0);
    vt[35] = mk(1, 0,0,0,0,       0,0,0,0,       0,0,     0,0,0,0,       0,0,    0,0,    0,0);

    // Reset state with a stray slave ready present
    rst_n = 1'b0;
    m0_valid = 1'b0; m0_address = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_address = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #3;
    check_vec(-1, mk(0, 0,0,0,0, 0,0,0,0, 1,'h12345678, 0,0,0,0, 0,0, 0,0, 0,0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_ready = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      apply(vt[i]);
      @(negedge clk);
      check_vec(i, vt[i]);
    end

    // Silent slave on an M0 read
    @(posedge clk); #1;
    m0_valid = 1'b1; m0_address = 3'd2; m0_wdata = '0; m0_wstrb = '0;
    s_ready = 1'b0; s_rdata = 32'h12;
    @(negedge clk);
    chk("to_idle_gnt", 0, 64'(gnt), 64'(2'b00));
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_gnt",     k, 64'(gnt),      64'(2'b01));
      chk("to_m0_ready", k, 64'(m0_ready), 64'(k == 8));
      chk("to_timeout", k, 64'(timeout),  64'(k == 8));
      chk("to_m0_rdata", k, 64'(m0_rdata), (k == 8) ? 64'hFFFF_FFFF : 64'h12);
    end
    // Pointer must have moved to M1 after the forced completion
    @(posedge clk); #1;
    m1_valid = 1'b1; m1_address = 3'd6;
    @(negedge clk);
    chk("to_after_gnt", 0, 64'(gnt), 64'(2'b00));
    chk("to_after_to",  0, 64'(timeout), 64'(0));
    @(posedge clk); #1;
    m0_valid = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    chk("to_next_gnt", 0, 64'(gnt), 64'(2'b10));
    chk("to_next_m1_ready", 0, 64'(m1_ready), 64'(0));
`else
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_gnt",      k, 64'(gnt),      64'(2'b01));
      chk("wait_m0_ready", k, 64'(m0_ready), 64'(0));
      chk("wait_timeout",  k, 64'(timeout),  64'(0));
    end
    @(posedge clk); #1;
    m0_valid = 1'b0;
    @(negedge clk);
    chk("wait_abort_ready", 0, 64'(m0_ready), 64'(0));
`endif
    @(posedge clk); #1;
    m0_valid = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    chk("final_gnt", 0, 64'(gnt), 64'(2'b00));
    chk("final_s_valid", 0, 64'(s_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
